// File: rtl/matrix_dump_reader.sv
// Read-only matrix walker: fetches rows x cols words from data memory in row-major
// order and streams them out over a valid/ready interface, one read in flight at a time.
module matrix_dump_reader #(
  parameter int N          = 12,
  parameter int ROW_STRIDE = 64,
  parameter int DIM_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     base_addr,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  output logic             busy,
  output logic             done,
  output logic             mem_write_en,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_datain,
  input  logic [N-1:0]     mem_dataout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_last
);

  localparam logic [N-1:0]     STRIDE = N'(ROW_STRIDE);
  localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);

  typedef enum logic [2:0] {IDLE, RD, CAP, SEND, FIN} state_t;

  state_t           state;
  logic [DIM_W-1:0] rows_q;
  logic [DIM_W-1:0] cols_q;
  logic [DIM_W-1:0] r;
  logic [DIM_W-1:0] c;
  logic [N-1:0]     row_base;

  assign mem_write_en = 1'b0;
  assign mem_datain   = '0;

  // RD gives the memory its one-cycle read latency; CAP latches the returned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      r         <= '0;
      c         <= '0;
      row_base  <= '0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (rows != '0 && cols != '0) begin
              rows_q   <= rows;
              cols_q   <= cols;
              row_base <= base_addr;
              mem_addr <= base_addr;
              r        <= '0;
              c        <= '0;
              state    <= RD;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          out_data  <= mem_dataout;
          out_valid <= 1'b1;
          out_last  <= (r == rows_q - ONE) && (c == cols_q - ONE);
          state     <= SEND;
        end
        SEND: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              if (c != cols_q - ONE) begin
                c        <= c + ONE;
                mem_addr <= mem_addr + N'(1);
              end else begin
                c        <= '0;
                r        <= r + ONE;
                row_base <= row_base + STRIDE;
                mem_addr <= row_base + STRIDE;
              end
              state <= RD;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/matrix_dump_reader.md
Name: matrix_dump_reader

Overview:
Read-side initiator for the data memory. On `start` it walks a rows×cols matrix stored at a base address with a fixed row stride. It issues one memory read per element and presents each word on a valid/ready output stream, for example toward a UART transmitter or a checker. It never writes memory; its write port is tied inactive.

Parameters:
N, 12, data and address width; matches the data memory word/address width
ROW_STRIDE, 64, address distance between consecutive matrix rows
DIM_W, 8, width of the rows/cols inputs

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  request a dump; sampled only in IDLE
base_addr  input  N  address of element (0,0)
rows  input  DIM_W  number of rows to read
cols  input  DIM_W  number of columns to read
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a dump finishes
mem_write_en  output  1  constant 0
mem_addr  output  N  registered read address to data memory
mem_datain  output  N  constant 0
mem_dataout  input  N  memory read data; valid one clock after the address edge
out_valid  output  1  out_data holds an element
out_ready  input  1  consumer accepts when high together with out_valid
out_data  output  N  element value
out_last  output  1  high with out_valid on the final element

Behaviour:
- Reset (async, any state): state=IDLE; mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. An in-flight dump is abandoned and no further words are emitted.
- Memory model: the address is sampled at posedge e; mem_dataout is valid after e and captured at e+1.
- FSM states: IDLE, RD, CAP, SEND, FIN.
- IDLE, start=1, rows≠0 and cols≠0: latch rows/cols; row_base<=base_addr; mem_addr<=base_addr; clear r/c counters; go to RD.
- IDLE, start=1, rows=0 or cols=0: go to FIN. No memory access and no output.
- RD: mem_addr stays stable; go to CAP (one cycle).
- CAP: out_data<=mem_dataout; out_valid<=1; out_last<=(r==rows-1 && c==cols-1); go to SEND.
- SEND: hold out_data, out_valid and out_last until out_valid&&out_ready.
  - Handshake on the last element: out_valid<=0, out_last<=0; go to FIN.
  - Handshake, otherwise:
    - If c<cols-1: c++, mem_addr<=mem_addr+1.
    - Else: c=0, r++, row_base<=row_base+ROW_STRIDE, mem_addr<=row_base+ROW_STRIDE.
    - out_valid<=0; go to RD.
- FIN: done=1 for exactly this cycle; go to IDLE. busy drops when IDLE is re-entered.
- Latency: out_valid rises two posedges after the start-accepting edge. Per-element minimum is 3 cycles with out_ready held high.
- Address arithmetic is modulo 2^N: wraps silently, no error flag.
- start is ignored while busy; the latched rows/cols/base are unaffected.
- Changes to rows/cols/base_addr after acceptance have no effect.
- out_ready is ignored while out_valid=0.
- Order is row-major. Exactly rows×cols words per dump. out_last is asserted on exactly one word.

Test Plan:
- Memory preloaded [4]=1,[5]=2,[68]=3,[69]=4. base=4, rows=2, cols=2, out_ready=1 → mem_addr sequence 4,5,68,69; stream 1,2,3,4; out_last only with 4; done pulses one cycle after the 4th handshake; mem_write_en never 1.
- Same setup with out_ready low for 5 cycles on each word → out_data and out_last stay stable while out_valid=1; same 4 words, no duplicates or drops.
- rows=0, cols=3 and start → busy high for 1 cycle, done pulse, out_valid never asserted, mem_addr unchanged.
- N=12, base=4094, rows=1, cols=3 → addresses 4094, 4095, 0; three words emitted, last on the one from address 0.
- Pulse start again during the second word of a 2×2 dump with base=100 → it is ignored; the dump finishes from base 4 with 4 words.
- Assert rst while in SEND on the 2nd word → out_valid, busy and done go 0 immediately. A new start after reset performs a complete 4-word dump from the first element.
